// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t    : control FSM states (IDLE accepts, RUN iterates, DONE presents)
//   NIB_W      : width of one nibble slice
//   cnt_width  : bits needed to count NIBS nibbles (clog2, never below 1)
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIB_W = 4;

  // Smallest w >= 1 with 2**w >= nibs, so a counter of this width can hold
  // every nibble index 0 .. nibs-1.
  function automatic int cnt_width(input int nibs);
    int w;
    w = 1;
    while ((1 << w) < nibs) w++;
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   sum  : a + b + cin, low four bits
//   cout : carry out of bit 3
//   pb   : group propagate (all four bits propagate)
//   gb   : group generate (the slice produces a carry by itself)
module CLA4Block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       pb,
  output logic       gb
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every internal carry is flattened from p/g and cin, so no carry ripples
  // from one bit to the next.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign pb   = &p;
  assign gb   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign cout = gb | (pb & cin);
  assign sum  = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial two's-complement adder: one CLA4 slice is reused over
// WIDTH/4 clocks, least significant nibble first.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; a, b, cin sampled on accept
//   out_valid/out_ready : result handshake; result held until taken
//   sum, cout           : a + b + cin modulo 2**WIDTH, and its carry out
//   overflow            : signed overflow of the addition
//   zero                : sum is all zeros
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int CNT_W = cnt_width(NIBS);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   sum_r;
  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cout;
  logic               pb_unused;
  logic               gb_unused;
  logic [WIDTH+NIB_W-1:0] sum_cat;
  logic [WIDTH-1:0]   sum_next;
  logic               last_nib;

  CLA4Block u_cla4 (
    .a    (op_a[NIB_W-1:0]),
    .b    (op_b[NIB_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout),
    .pb   (pb_unused),
    .gb   (gb_unused)
  );

  // New nibble enters at the top while the register moves right, so after
  // NIBS steps the first nibble has reached bit 0. Written as a wide
  // concatenation so it also works when WIDTH is a single nibble.
  assign sum_cat  = {slice_sum, sum_r};
  assign sum_next = sum_cat[WIDTH+NIB_W-1:NIB_W];
  assign last_nib = (cnt == CNT_W'(NIBS - 1));

  assign sum       = sum_r;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last_nib)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture on accept, one nibble per RUN cycle, and the flags are
  // computed from the fully assembled sum on the final nibble so they stay
  // frozen throughout DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sum_r    <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= a;
            op_b   <= b;
            carry  <= cin;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            cnt    <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> NIB_W;
          op_b  <= op_b >> NIB_W;
          sum_r <= sum_next;
          carry <= slice_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_nib) begin
            cout     <= slice_cout;
            overflow <= (sign_a == sign_b) && (sum_next[WIDTH-1] != sign_a);
            zero     <= (sum_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed WIDTH=16 vectors,
// backpressure and mid-operation reset sequences, then randomized WIDTH=32
// operations against an arithmetic reference model.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cout16, ovf16, zero16;

  logic        in_valid32, in_ready32, cin32, out_valid32, out_ready32;
  logic [31:0] a32, b32, sum32;
  logic        cout32, ovf32, zero32;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16),
    .overflow(ovf16), .zero(zero16)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32),
    .out_ready(out_ready32), .sum(sum32), .cout(cout32),
    .overflow(ovf32), .zero(zero32)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete 16-bit operation with out_ready high: accept, latency,
  // result fields, then the single-cycle out_valid pulse.
  task automatic apply_stimulus(input logic [15:0] va, input logic [15:0] vb,
                                input logic vcin, input logic [15:0] esum,
                                input logic ecout, input logic eovf,
                                input logic ezero, input string tag);
    int n;
    n = 0;
    while (!in_ready16 && n < 20) begin tick(); n++; end
    check_output({tag, "_in_ready"}, 64'(in_ready16), 64'd1);
    a16 = va; b16 = vb; cin16 = vcin; in_valid16 = 1'b1; out_ready16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = ~vcin;
    n = 0;
    while (!out_valid16 && n < 20) begin tick(); n++; end
    check_output({tag, "_latency"}, 64'(n), 64'd4);
    check_output({tag, "_sum"}, 64'(sum16), 64'(esum));
    check_output({tag, "_cout"}, 64'(cout16), 64'(ecout));
    check_output({tag, "_ovf"}, 64'(ovf16), 64'(eovf));
    check_output({tag, "_zero"}, 64'(zero16), 64'(ezero));
    tick();
    check_output({tag, "_valid_drop"}, 64'(out_valid16), 64'd0);
  endtask

  initial begin
    int n;
    bit saw_valid;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    #1;
    check_output("reset_in_ready", 64'(in_ready16), 64'd1);
    check_output("reset_out_valid", 64'(out_valid16), 64'd0);
    check_output("reset_sum", 64'(sum16), 64'd0);
    check_output("reset_flags", 64'({cout16, ovf16, zero16}), 64'd0);
    #12 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum,
                     vecs[i].cout, vecs[i].ovf, vecs[i].zero,
                     $sformatf("vec%0d", i));
    end

    // Backpressure: result must sit untouched while new operands are offered.
    out_ready16 = 1'b0;
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 20) begin tick(); n++; end
    check_output("bp_latency", 64'(n), 64'd4);
    for (int k = 0; k < 6; k++) begin
      in_valid16 = k[0];
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      tick();
      check_output("bp_sum_hold", 64'(sum16), 64'h3333);
      check_output("bp_valid_hold", 64'(out_valid16), 64'd1);
      check_output("bp_in_ready", 64'(in_ready16), 64'd0);
    end
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    tick();
    check_output("bp_release_valid", 64'(out_valid16), 64'd0);
    check_output("bp_release_ready", 64'(in_ready16), 64'd1);
    tick();
    in_valid16 = 1'b0; a16 = 16'hDEAD;
    n = 0;
    while (!out_valid16 && n < 20) begin tick(); n++; end
    check_output("bp_next_latency", 64'(n), 64'd4);
    check_output("bp_next_sum", 64'(sum16), 64'h0002);
    tick();

    // Reset in the second RUN cycle discards the operation entirely.
    a16 = 16'h5555; b16 = 16'h1111; cin16 = 1'b0; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_in_ready", 64'(in_ready16), 64'd1);
    check_output("rst_mid_out_valid", 64'(out_valid16), 64'd0);
    check_output("rst_mid_sum", 64'(sum16), 64'd0);
    #2 rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid16) saw_valid = 1'b1;
    end
    check_output("rst_no_valid", 64'(saw_valid), 64'd0);
    check_output("rst_after_ready", 64'(in_ready16), 64'd1);
    apply_stimulus(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0,
                   "post_rst");

    // Randomized 32-bit operations with random result stalls.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      logic        rc;
      logic [63:0] usum;
      longint      ssum;
      logic [31:0] esum;
      logic        ecout, eovf, ezero;
      int          stall;

      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (i % 50 == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0001; end
      usum  = 64'(ra) + 64'(rb) + 64'(rc);
      ssum  = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rc);
      esum  = usum[31:0];
      ecout = usum[32];
      eovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      ezero = (esum == 32'd0);

      n = 0;
      while (!in_ready32 && n < 40) begin tick(); n++; end
      check_output("r32_in_ready", 64'(in_ready32), 64'd1);
      a32 = ra; b32 = rb; cin32 = rc; in_valid32 = 1'b1; out_ready32 = 1'b0;
      tick();
      in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom;
      n = 0;
      while (!out_valid32 && n < 40) begin tick(); n++; end
      check_output("r32_latency", 64'(n), 64'd8);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) tick();
      check_output("r32_sum", 64'(sum32), 64'(esum));
      check_output("r32_cout", 64'(cout32), 64'(ecout));
      check_output("r32_ovf", 64'(ovf32), 64'(eovf));
      check_output("r32_zero", 64'(zero32), 64'(ezero));
      out_ready32 = 1'b1;
      tick();
      out_ready32 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle, nibble-serial two's-complement adder. It sits between operand-producing logic and the 4-bit carry-lookahead slice, and time-multiplexes one CLA4 slice over a WIDTH-bit operand pair, one nibble per clock, LSB first. A valid/ready handshake is used on both sides. It trades latency for area wherever a full-width CLA tree is not justified.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and at least 4; otherwise elaboration fails.
- NIBS, WIDTH/4, derived nibble count. Not user-overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b, cin presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst_n is low:
  - state = IDLE; nibble counter = 0; carry register = 0.
  - sum, cout, overflow, zero and out_valid = 0.
  - in_ready = 1, since it is decoded from IDLE.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
    - On in_valid & in_ready: latch a and b into operand shift registers, carry register <= cin, latch sign bits a[WIDTH-1] and b[WIDTH-1], counter <= 0, go to RUN.
  - RUN: in_ready = 0, out_valid = 0.
    - Each cycle, the CLA4 slice adds opA[3:0], opB[3:0] and the carry register.
    - Both operand registers shift right by 4.
    - The slice sum nibble shifts into sum[WIDTH-1:WIDTH-4] and the sum register shifts right by 4.
    - carry register <= slice Cout; counter++.
    - When counter == NIBS-1 (the final nibble, same edge): go to DONE, out_valid <= 1, cout <= slice Cout.
    - overflow <= (signA == signB) & (final sum MSB != signA).
    - zero <= (final sum == 0), evaluated on the fully assembled sum.
  - DONE: out_valid = 1, in_ready = 0.
    - sum, cout, overflow and zero are held stable.
    - On out_valid & out_ready: out_valid <= 0, go to IDLE.
    - No same-cycle re-accept.
- Latency:
  - Accept edge T; out_valid rises at edge T+NIBS (16-bit: 4 cycles).
  - Minimum initiation interval is NIBS+2 cycles.
- in_valid while not in IDLE: ignored. The producer must hold its operands; none are sampled.
- Operand changes after acceptance have no effect.
- Results are guaranteed only while out_valid = 1. Between results the sum register contents are undefined but deterministic; they are not cleared.
- cin = 1 with a = b = all-ones: sum = all-ones, cout = 1, overflow = 0.
- Reset mid-RUN or mid-DONE: immediately abort to IDLE with all outputs as in reset. The partial result is discarded and never signalled.
- The slice group Pb/Gb outputs are unused and left unconnected.

Decomposition:
- Shared package:
  - state typedef {IDLE, RUN, DONE}.
  - NIB_W = 4.
  - Counter width function clog2(NIBS), minimum 1.
- Sub-module: the existing 4-bit CLA slice CLA4Block is instantiated once as the nibble datapath. No other sub-modules; FSM, shift registers and flags are in-line.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum=0x5555, cout=0, overflow=0, zero=0; out_valid exactly 4 cycles after accept, for one cycle.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, overflow=0. Repeat with a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1, cout=0.
- a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1, overflow=1. With a=b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, overflow=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid with new operands -> outputs stable, in_ready=0, no new op accepted. The first accept occurs only after the out_ready handshake and a return to IDLE.
- Reset pulse on the 2nd RUN cycle -> out_valid never rises for that op, in_ready=1 during and after reset. The next op a=0x0F0F, b=0x00F1 yields 0x1000 with correct 4-cycle latency.
- WIDTH=32, 1000 random operand/cin sets with random out_ready stalls vs a behavioural model -> sum, cout, overflow and zero all match; latency exactly 8.
